// File: rtl/toggle_pulse_debounce.sv
`default_nettype none
// ============================================================================
// Module      : toggle_pulse_debounce
// Description : Turns the raw lock push-button into a clean one-cycle toggle
//               request for the lock-state T flip-flop.
//               A 2-flop synchronizer feeds a debounce FSM with a stability
//               counter. Each accepted press produces at most one registered
//               pulse. A wrapping 8-bit count of accepted (enabled) presses
//               is kept for the processor.
// Ports       : clk          in   system clock, rising edge
//               clr_n        in   asynchronous active-low reset
//               btn_in       in   raw asynchronous button level
//               enable       in   1: accepted presses emit toggle_pulse
//               toggle_pulse out  one-cycle pulse to the lock TFF T input
//               btn_level    out  debounced pressed level (1 = pressed)
//               press_count  out  accepted presses while enabled, wraps 255->0
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_pulse_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_in,
  input  logic       enable,
  output logic       toggle_pulse,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Polarity is corrected ahead of the synchronizer so that the reset value
  // of the sync flops (0) always means "not pressed".
  logic w_btn_pressed;
  assign w_btn_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= w_btn_pressed;
      sync2_q <= sync1_q;
    end
  end

  logic btn_s;
  assign btn_s = sync2_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             level_q;
  logic [7:0]       count_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      // Pulse is only ever set on the HELD-entry edge, so it can never be
      // high on two consecutive cycles.
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_s) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end

        ST_PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            // enable is sampled only here; a press accepted while disabled
            // is consumed and never pulses later.
            state_q <= ST_HELD;
            level_q <= 1'b1;
            pulse_q <= enable;
            count_q <= count_q + {7'd0, enable};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_HELD: begin
          if (!btn_s) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end

        ST_RELEASE_WAIT: begin
          if (btn_s) begin
            // Release bounce: back to HELD without a new pulse.
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q <= ST_IDLE;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign toggle_pulse = pulse_q;
  assign btn_level    = level_q;
  assign press_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_pulse_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_pulse_debounce
// Description : Scoreboard bench for toggle_pulse_debounce. The stimulus side
//               runs a run-length reference model of the debounce rule and
//               queues each expected pulse (edge number and press count); a
//               monitor pops and compares whenever the DUT pulses, and also
//               tracks btn_level and press_count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_debounce;

  localparam int DC = 4;

  logic       clk;
  logic       clr_n;
  logic       btn_in;
  logic       enable;
  logic       toggle_pulse;
  logic       btn_level;
  logic [7:0] press_count;

  toggle_pulse_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .btn_in      (btn_in),
    .enable      (enable),
    .toggle_pulse(toggle_pulse),
    .btn_level   (btn_level),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned t;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: the two most recent pressed values driven
  // (they reach the debouncer two edges later), the debounced level, the
  // length of the current run disagreeing with it, and the press count.
  bit         d1, d2;
  bit         m_level;
  int         m_run;
  int         m_count;
  bit         exp_level;
  logic [7:0] exp_cnt;
  bit         cur_p, cur_en;
  bit         in_reset;
  bit         prev_pulse;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drives values for the upcoming edge and advances the model by that edge.
  task automatic drive_and_model(input bit p, input bit en);
    int unsigned t;
    bit          s;
    btn_in = ~p;
    enable = en;
    cur_p  = p;
    cur_en = en;
    t  = cyc + 1;
    s  = d2;
    d2 = d1;
    d1 = p;
    if (s != m_level) begin
      m_run++;
      if (m_run == DC + 1) begin
        m_level = s;
        m_run   = 0;
        if (m_level && en) begin
          m_count = (m_count + 1) % 256;
          q.push_back('{t, 8'(m_count)});
        end
      end
    end else begin
      m_run = 0;
    end
    exp_level = m_level;
    exp_cnt   = 8'(m_count);
  endtask

  task automatic step(input bit p, input bit en);
    @(negedge clk);
    drive_and_model(p, en);
  endtask

  task automatic hold(input bit p, input int n, input bit en);
    for (int i = 0; i < n; i++) step(p, en);
  endtask

  // Asserts reset now (asynchronously), checks outputs dropped at once,
  // then releases on a falling edge with the button left as it was.
  task automatic reset_now();
    in_reset = 1'b1;
    clr_n    = 1'b0;
    #1;
    chk("rst_toggle_pulse", int'(toggle_pulse), 0);
    chk("rst_btn_level",    int'(btn_level),    0);
    chk("rst_press_count",  int'(press_count),  0);
    q.delete();
    d1 = 1'b0; d2 = 1'b0;
    m_level = 1'b0; m_run = 0; m_count = 0;
    exp_level = 1'b0; exp_cnt = 8'd0;
    prev_pulse = 1'b0;
    repeat (2) @(negedge clk);
    clr_n    = 1'b1;
    in_reset = 1'b0;
    drive_and_model(cur_p, cur_en);
  endtask

  // Monitor: pops the scoreboard on every DUT pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!in_reset) begin
        while (q.size() > 0 && q[0].t < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_pulse: expected at cycle %0d count %0d, got no pulse",
                   q[0].t, q[0].cnt);
          void'(q.pop_front());
        end
        if (toggle_pulse) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: got 1 expected 0", cyc);
          end else begin
            e = q.pop_front();
            chk("pulse_cycle", int'(cyc), int'(e.t));
            chk("pulse_count", int'(press_count), int'(e.cnt));
          end
          chk("pulse_not_consecutive", int'(prev_pulse), 0);
        end
        chk("btn_level",   int'(btn_level),   int'(exp_level));
        chk("press_count", int'(press_count), int'(exp_cnt));
        prev_pulse = toggle_pulse;
      end
    end
  end

  initial begin
    bit p;
    clr_n    = 1'b0;
    btn_in   = 1'b1;
    enable   = 1'b1;
    cur_p    = 1'b0;
    cur_en   = 1'b1;
    in_reset = 1'b1;
    @(posedge clk);
    #2;
    reset_now();

    // Clean press
    hold(1'b1, 20, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Press bounce shorter than the debounce window
    hold(1'b1, 3, 1'b1);
    hold(1'b0, 1, 1'b1);
    hold(1'b1, 2, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Release bounce
    hold(1'b1, 10, 1'b1);
    hold(1'b0, 2, 1'b1);
    hold(1'b1, 2, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Disabled at accept, enabled while still held, then a normal press
    hold(1'b1, 8, 1'b0);
    hold(1'b1, 10, 1'b1);
    hold(1'b0, 10, 1'b1);
    hold(1'b1, 10, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Count wrap
    repeat (256) begin
      hold(1'b1, 6, 1'b1);
      hold(1'b0, 6, 1'b1);
    end

    // Reset during PRESS_WAIT with the button kept pressed across release
    hold(1'b1, 4, 1'b1);
    #2;
    reset_now();
    hold(1'b1, 12, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Reset during the pulse cycle
    for (int i = 0; i < 20 && q.size() == 0; i++) step(1'b1, 1'b1);
    @(posedge clk);
    #2;
    reset_now();
    hold(1'b1, 12, 1'b1);
    hold(1'b0, 10, 1'b1);

    // Random runs of pressed/released with random enable per cycle
    p = 1'b0;
    repeat (400) begin
      int n;
      p = ~p;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 12))
                                      : int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) step(p, $urandom_range(0, 3) != 0);
    end
    hold(1'b0, 12, 1'b1);

    @(posedge clk);
    #2;
    chk("scoreboard_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
